instr_fetch_unit: RTL

- Requester side of the word-addressed instruction memory. The memory returns `mem[pc]` on `instruction` one clock after `pc` is presented.
- The block generates the `pc` sequence, tracks the single in-flight read and presents a fetched instruction with valid, pc and stall handshake to decode.
- Handles branch/jump redirects (squashing the wrong-path word) and out-of-range fetch faults.
- Sits between the memory and the decode stage.

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: drives the word address to a one-cycle-latency memory,
// tracks the single in-flight read, and hands right-path words to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_fetchPc;
  logic [31:0] r_inflightPc;
  logic        r_inflightValid;
  logic        r_fault;
  logic [31:0] r_fetchCount;

  logic        w_issue;
  logic        w_outOfRange;
  logic        w_accept;

  // The start cycle already issues the first request so the first word returns next cycle.
  assign w_issue      = (r_state == RUN) || ((r_state == IDLE) && start);
  assign w_outOfRange = (pc >= 32'(MEM_DEPTH));
  assign w_accept     = if_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = w_outOfRange ? FAULT : RUN;
      RUN:     if (w_outOfRange) w_nextState = FAULT;
      FAULT:   w_nextState = FAULT;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    if (redirect_valid && (r_state == RUN)) begin
      pc = redirect_target;
    end else if (stall && r_inflightValid) begin
      pc = r_inflightPc;
    end else begin
      pc = r_fetchPc;
    end
    if_valid = r_inflightValid && (r_state == RUN) && !redirect_valid;
  end

  // On a fault the offending address is parked in fetch_pc so pc holds it while faulted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetchPc       <= RESET_PC;
      r_inflightPc    <= 32'd0;
      r_inflightValid <= 1'b0;
      r_fault         <= 1'b0;
      r_fetchCount    <= 32'd0;
    end else begin
      if (w_issue) begin
        if (w_outOfRange) begin
          r_inflightValid <= 1'b0;
          r_fault         <= 1'b1;
          r_fetchPc       <= pc;
        end else begin
          r_inflightPc    <= pc;
          r_inflightValid <= 1'b1;
          r_fetchPc       <= pc + 32'd1;
        end
      end
      if (w_accept) begin
        r_fetchCount <= r_fetchCount + 32'd1;
      end
    end
  end

  assign if_instr    = instruction;
  assign if_pc       = r_inflightPc;
  assign fault       = r_fault;
  assign fetch_count = r_fetchCount;

endmodule
